// File: rtl/alu_serial_addsub.sv
// Bit-serial add/subtract slice: adds A and (B ^ {binv}) + binv one bit per clock, LSB first,
// and reports result, carry, signed overflow and zero through a start/busy/done handshake.
module alu_serial_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             binv,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] shreg;
  logic             carry;
  logic [CW-1:0]    count;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] shreg_next;

  assign sum_bit    = opa[0] ^ opb[0] ^ carry;
  assign carry_next = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
  assign shreg_next = {sum_bit, shreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      shreg     <= '0;
      carry     <= 1'b0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b ^ {WIDTH{binv}};
            carry <= binv;
            count <= '0;
            shreg <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= carry_next;
          shreg <= shreg_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            // On the MSB edge the prior carry is the carry into the MSB, so
            // overflow is formed here directly rather than from a stored copy.
            state     <= DONE;
            done      <= 1'b1;
            result    <= shreg_next;
            carry_out <= carry_next;
            overflow  <= carry ^ carry_next;
            zero      <= (shreg_next == '0);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_addsub.sv
// Randomized and directed checks of alu_serial_addsub against a plain-arithmetic model.
module tb_alu_serial_addsub;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         binv = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry_out, overflow, zero;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] prev_result = '0;

  alu_serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .binv(binv), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbinv,
                                output logic [W-1:0] r, output logic c, output logic v, output logic z);
    logic [W:0]   full;
    logic [W-1:0] bm;
    bm   = mbinv ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bm} + {{W{1'b0}}, mbinv};
    r = full[W-1:0];
    c = full[W];
    v = (ma[W-1] == bm[W-1]) && (r[W-1] != ma[W-1]);
    z = (r == '0);
  endfunction

  // Drives one operation; reports latency of done, whether outputs stayed quiet mid-run,
  // and whether the handshake returned to idle one edge after done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbinv,
                        output logic [W-1:0] r, output logic c, output logic v, output logic z,
                        output int lat, output bit quiet, output bit ended);
    @(negedge clk);
    a = ta; b = tb; binv = tbinv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; binv = 1'($urandom_range(0, 1));
    quiet = busy && !done;
    lat = -1;
    r = 'x; c = 1'bx; v = 1'bx; z = 1'bx;
    for (int k = 1; k <= W + 4; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        r = result; c = carry_out; v = overflow; z = zero;
        if (!busy) quiet = 1'b0;
        break;
      end
      if (!busy || result !== prev_result) quiet = 1'b0;
    end
    @(posedge clk); #1;
    ended = !done && !busy && (result === r);
  endtask

  task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbinv);
    logic [W-1:0] r, er;
    logic c, v, z, ec, ev, ez;
    int lat;
    bit quiet, ended;
    model(ta, tb, tbinv, er, ec, ev, ez);
    run_op(ta, tb, tbinv, r, c, v, z, lat, quiet, ended);
    $display("op %s a=%h b=%h binv=%0d -> result=%h c=%0d v=%0d z=%0d lat=%0d",
             name, ta, tb, tbinv, r, c, v, z, lat);
    checks++;
    if ({r, c, v, z} !== {er, ec, ev, ez}) begin
      failures++;
      $display("FAIL %s flags: got r=%h c=%0d v=%0d z=%0d, want r=%h c=%0d v=%0d z=%0d",
               name, r, c, v, z, er, ec, ev, ez);
    end
    checks++;
    if (lat !== W) begin
      failures++;
      $display("FAIL %s latency: got %0d, want %0d", name, lat, W);
    end
    checks++;
    if (quiet !== 1'b1 || ended !== 1'b1) begin
      failures++;
      $display("FAIL %s handshake: got quiet=%0d ended=%0d, want 1 1", name, quiet, ended);
    end
    prev_result = er;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, result, carry_out, overflow, zero} !== '0) begin
      failures++;
      $display("FAIL reset_state: got busy=%0d done=%0d result=%h c=%0d v=%0d z=%0d, want all 0",
               busy, done, result, carry_out, overflow, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_result = '0;
  endtask

  task automatic test_directed();
    check_op("add_5_3", 32'd5, 32'd3, 1'b0);
    check_op("sub_5_7", 32'd5, 32'd7, 1'b1);
    check_op("ovf_pos", 32'h7FFF_FFFF, 32'd1, 1'b0);
    check_op("sub_eq", 32'h1234_5678, 32'h1234_5678, 1'b1);
    check_op("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0);
    check_op("ovf_neg", 32'h8000_0000, 32'd1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      check_op("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] ta, tb, er;
    logic tbinv, ec, ev, ez;
    logic [W-1:0] r;
    int ndone, lat;
    ta = $urandom; tb = $urandom; tbinv = 1'($urandom_range(0, 1));
    model(ta, tb, tbinv, er, ec, ev, ez);
    @(negedge clk);
    a = ta; b = tb; binv = tbinv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lat = -1; r = 'x;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      start = (k == 5 || k == 31);
      if (start) begin a = $urandom; b = $urandom; binv = ~tbinv; end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin ndone++; lat = k; r = result; end
    end
    $display("op ignore_start a=%h b=%h binv=%0d -> result=%h dones=%0d lat=%0d",
             ta, tb, tbinv, r, ndone, lat);
    checks++;
    if (ndone !== 1 || lat !== W) begin
      failures++;
      $display("FAIL ignore_start pulses: got dones=%0d lat=%0d, want 1 %0d", ndone, lat, W);
    end
    checks++;
    if (r !== er) begin
      failures++;
      $display("FAIL ignore_start result: got %h, want %h", r, er);
    end
    prev_result = er;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta, tb, er;
    logic ec, ev, ez;
    int edges[$];
    int bad;
    ta = $urandom; tb = $urandom;
    model(ta, tb, 1'b0, er, ec, ev, ez);
    bad = 0;
    @(negedge clk);
    a = ta; b = tb; binv = 1'b0; start = 1'b1;
    for (int k = 0; k <= 3 * (W + 2) - 1; k++) begin
      @(posedge clk); #1;
      if (done) begin
        edges.push_back(k);
        if (result !== er) bad++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 4) @(posedge clk);
    #1;
    $display("op back_to_back a=%h b=%h -> dones=%0d result=%h", ta, tb, edges.size(), result);
    checks++;
    if (edges.size() !== 3 || edges[0] !== W || edges[1] !== 2 * W + 2 || edges[2] !== 3 * W + 4) begin
      failures++;
      $display("FAIL back_to_back spacing: got %0d dones first=%0d, want 3 at %0d,%0d,%0d",
               edges.size(), (edges.size() > 0) ? edges[0] : -1, W, 2 * W + 2, 3 * W + 4);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL back_to_back result: got %0d wrong results, want 0 (expected %h)", bad, er);
    end
    prev_result = er;
  endtask

  task automatic test_reset_midrun();
    int ndone;
    @(negedge clk);
    a = $urandom; b = $urandom; binv = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("op reset_midrun -> busy=%0d done=%0d result=%h", busy, done, result);
    checks++;
    if ({busy, done, result, carry_out, overflow, zero} !== '0) begin
      failures++;
      $display("FAIL reset_midrun outputs: got busy=%0d done=%0d result=%h c=%0d v=%0d z=%0d, want all 0",
               busy, done, result, carry_out, overflow, zero);
    end
    ndone = 0;
    repeat (3) begin @(posedge clk); #1; if (done) ndone++; end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin @(posedge clk); #1; if (done) ndone++; end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL reset_midrun done: got %0d pulses, want 0", ndone);
    end
    prev_result = '0;
    check_op("after_reset", 32'd1, 32'd1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
